// File: rtl/sram_like_arbiter_2x1.sv
// sram_like_arbiter_2x1
// Two sram-like masters (m0 = instruction, m1 = data) share a single sram-like
// slave port. Address phases are arbitrated with zero-cycle latency. A request
// that has been presented but not yet accepted is locked so that s_req never
// changes underneath the slave. An owner FIFO records which master issued each
// accepted transfer, so that in-order responses can be steered back to it.
module sram_like_arbiter_2x1 #(
  parameter int OUTST_DEPTH = 4,
  parameter bit RR_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (instruction side)
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  // master 1 (data side)
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  // shared slave port
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err_orphan
);

  localparam int AW = $clog2(OUTST_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(OUTST_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   rr_last, rr_last_next;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          owner_mem [OUTST_DEPTH];

  logic fifo_full, fifo_empty;
  logic sel, sel_valid, sel_req;
  logic req_int, push, pop, head;

  // Full/empty come from the registered count only, so a pop in a full cycle
  // frees a slot for the next cycle but never for the current one.
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = owner_mem[rd_ptr];

  // Pick the master that drives the slave port this cycle.
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    case (state)
      ST_LOCK0: begin
        sel       = 1'b0;
        sel_valid = 1'b1;
      end
      ST_LOCK1: begin
        sel       = 1'b1;
        sel_valid = 1'b1;
      end
      default: begin
        if (m0_req && m1_req) begin
          sel       = RR_EN ? ~rr_last : 1'b1;
          sel_valid = 1'b1;
        end else if (m0_req) begin
          sel       = 1'b0;
          sel_valid = 1'b1;
        end else if (m1_req) begin
          sel       = 1'b1;
          sel_valid = 1'b1;
        end else begin
          sel       = 1'b0;
          sel_valid = 1'b0;
        end
      end
    endcase
  end

  assign sel_req = sel ? m1_req : m0_req;
  assign req_int = sel_valid & sel_req & ~fifo_full;
  assign push    = req_int & s_addr_ok;
  assign pop     = s_data_ok & ~fifo_empty;

  // Drive the muxed request fields; everything is forced low during reset.
  always_comb begin
    s_req   = 1'b0;
    s_wr    = 1'b0;
    s_size  = 2'd0;
    s_addr  = 32'd0;
    s_wdata = 32'd0;
    if (!rst && sel_valid) begin
      s_req   = req_int;
      s_wr    = sel ? m1_wr    : m0_wr;
      s_size  = sel ? m1_size  : m0_size;
      s_addr  = sel ? m1_addr  : m0_addr;
      s_wdata = sel ? m1_wdata : m0_wdata;
    end else begin
      s_req   = 1'b0;
    end
  end

  // Address acknowledge goes only to the selected master.
  assign m0_addr_ok = ~rst & push & ~sel;
  assign m1_addr_ok = ~rst & push &  sel;

  // Responses are steered to the FIFO head owner in the same cycle.
  assign m0_data_ok = ~rst & pop & ~head;
  assign m1_data_ok = ~rst & pop &  head;
  assign m0_rdata   = m0_data_ok ? s_rdata : 32'd0;
  assign m1_rdata   = m1_data_ok ? s_rdata : 32'd0;

  // Next-state logic: lock on a presented-but-unaccepted request, unlock on accept.
  always_comb begin
    state_next   = state;
    rr_last_next = rr_last;
    case (state)
      ST_IDLE: begin
        if (push) begin
          rr_last_next = sel;
        end else if (req_int) begin
          state_next = sel ? ST_LOCK1 : ST_LOCK0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOCK0: begin
        if (push) begin
          state_next   = ST_IDLE;
          rr_last_next = 1'b0;
        end else begin
          state_next = ST_LOCK0;
        end
      end
      ST_LOCK1: begin
        if (push) begin
          state_next   = ST_IDLE;
          rr_last_next = 1'b1;
        end else begin
          state_next = ST_LOCK1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state and round-robin history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_last <= 1'b0;
    end else begin
      state   <= state_next;
      rr_last <= rr_last_next;
    end
  end

  // Owner FIFO: push the granted id on accept, pop on each matched response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUTST_DEPTH; i++) begin
        owner_mem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        owner_mem[wr_ptr] <= sel;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a response that has no outstanding owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (s_data_ok && fifo_empty) begin
      err_orphan <= 1'b1;
    end else begin
      err_orphan <= err_orphan;
    end
  end

endmodule
